// File: rtl/segment_split_unroll.sv
// Branch FIFO: first-word-fall-through, wrap-bit pointers, synchronous flush.
// Latency: a word written at edge N is at the head right after edge N.
// Backpressure: full/empty flags only; the caller gates push with !full and pop with !empty.
module segment_split_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic              empty,
  output logic              full,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head_idx;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // While empty, show the slot just behind the read pointer: it still holds the
  // last word popped, and the next push lands on the read slot, not this one.
  assign head_idx = empty ? (rd_ptr[AW-1:0] - AW'(1)) : rd_ptr[AW-1:0];
  assign head     = mem[head_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// Steers combined segment words into if/else branch streams by condition word.
// Latency: word accepted at edge N is valid on its branch output in cycle N+1.
// Backpressure: in_ready drops when either branch FIFO is full or during flush.
module segment_split_unroll #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] input_bit,
  input  logic [DATA_W-1:0] segment_8_combine,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] segment_8_if,
  output logic              else_valid,
  input  logic              else_ready,
  output logic [DATA_W-1:0] segment_8_else,
  output logic [CNT_W-1:0]  if_count,
  output logic [CNT_W-1:0]  else_count
);
  logic if_empty, if_full, else_empty, else_full;
  logic if_cond, accept, push_if, push_else;

  assign in_ready  = !if_full && !else_full && !flush;
  assign if_cond   = |input_bit;
  assign accept    = in_valid && in_ready;
  assign push_if   = accept && if_cond;
  assign push_else = accept && !if_cond;

  assign if_valid   = !if_empty;
  assign else_valid = !else_empty;

  segment_split_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_if_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push_if),
    .push_dat (segment_8_combine),
    .pop      (if_valid && if_ready),
    .empty    (if_empty),
    .full     (if_full),
    .head     (segment_8_if)
  );

  segment_split_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_else_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push_else),
    .push_dat (segment_8_combine),
    .pop      (else_valid && else_ready),
    .empty    (else_empty),
    .full     (else_full),
    .head     (segment_8_else)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_count   <= '0;
      else_count <= '0;
    end else if (flush) begin
      if_count   <= '0;
      else_count <= '0;
    end else begin
      if (push_if && (if_count != '1))     if_count   <= if_count + CNT_W'(1);
      if (push_else && (else_count != '1)) else_count <= else_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_segment_split_unroll.sv
// Directed bench for segment_split_unroll: ordering, full/empty boundaries, saturation, flush, async reset.
module tb_segment_split_unroll;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] input_bit;
  logic [DATA_W-1:0] segment_8_combine;
  logic              if_valid, if_ready;
  logic [DATA_W-1:0] segment_8_if;
  logic              else_valid, else_ready;
  logic [DATA_W-1:0] segment_8_else;
  logic [CNT_W-1:0]  if_count, else_count;

  int errors = 0;
  int checks = 0;

  segment_split_unroll #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .input_bit         (input_bit),
    .segment_8_combine (segment_8_combine),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .segment_8_if      (segment_8_if),
    .else_valid        (else_valid),
    .else_ready        (else_ready),
    .segment_8_else    (segment_8_else),
    .if_count          (if_count),
    .else_count        (else_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] cond, input logic [DATA_W-1:0] d);
    in_valid          = v;
    input_bit         = cond;
    segment_8_combine = d;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0);
    if_ready = 1'b1; else_ready = 1'b1;
    #3;
    chk("rst_in_ready",   in_ready, 1);
    chk("rst_if_valid",   if_valid, 0);
    chk("rst_else_valid", else_valid, 0);
    chk("rst_if_count",   if_count, 0);
    chk("rst_else_count", else_count, 0);
    chk("rst_seg_if",     segment_8_if, 0);
    chk("rst_seg_else",   segment_8_else, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Alternating branches, both consumers ready.
    drive(1'b1, 32'd1, 32'hA0); step();
    chk("alt_if_v0",  if_valid, 1);
    chk("alt_if_d0",  segment_8_if, 32'hA0);
    drive(1'b1, 32'd0, 32'hA1); step();
    chk("alt_if_v1",  if_valid, 0);
    chk("alt_el_v1",  else_valid, 1);
    chk("alt_el_d1",  segment_8_else, 32'hA1);
    drive(1'b1, 32'd1, 32'hA2); step();
    chk("alt_if_v2",  if_valid, 1);
    chk("alt_if_d2",  segment_8_if, 32'hA2);
    chk("alt_el_v2",  else_valid, 0);
    drive(1'b1, 32'd0, 32'hA3); step();
    chk("alt_el_v3",  else_valid, 1);
    chk("alt_el_d3",  segment_8_else, 32'hA3);
    chk("alt_if_hold", segment_8_if, 32'hA2);
    drive(1'b0, '0, '0); step();
    chk("alt_el_v4",   else_valid, 0);
    chk("alt_el_hold", segment_8_else, 32'hA3);
    chk("alt_if_cnt",  if_count, 2);
    chk("alt_el_cnt",  else_count, 2);

    // Fill the if FIFO with its consumer stalled.
    if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("full_rdy_before", in_ready, 1);
      drive(1'b1, 32'h8000_0000, 32'hB0 + i); step();
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_if_head",  segment_8_if, 32'hB0);
    chk("full_if_cnt",   if_count, 6);
    drive(1'b1, 32'h8000_0000, 32'hB4); step();
    chk("stall_in_ready", in_ready, 0);
    chk("stall_if_cnt",   if_count, 6);
    if_ready = 1'b1; step();
    chk("unstall_in_ready", in_ready, 1);
    chk("unstall_head",     segment_8_if, 32'hB1);
    if_ready = 1'b0; step();
    chk("refill_in_ready", in_ready, 0);
    chk("refill_if_cnt",   if_count, 7);
    drive(1'b0, '0, '0);
    if_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_if_valid", if_valid, 1);
      chk("drain_if_data",  segment_8_if, 32'hB0 + i);
      step();
    end
    chk("drain_if_empty", if_valid, 0);

    // Else FIFO at 3 entries, simultaneous push and pop.
    else_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd0, 32'hC0 + i); step();
    end
    chk("pp_el_valid0", else_valid, 1);
    chk("pp_el_head0",  segment_8_else, 32'hC0);
    else_ready = 1'b1;
    drive(1'b1, 32'd0, 32'hC3); step();
    chk("pp_el_valid1", else_valid, 1);
    chk("pp_el_head1",  segment_8_else, 32'hC1);
    chk("pp_in_ready",  in_ready, 1);
    else_ready = 1'b0;
    drive(1'b1, 32'd0, 32'hC4); step();
    chk("pp_occ4_in_ready", in_ready, 0);
    drive(1'b0, '0, '0);
    else_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("pp_drain_data", segment_8_else, 32'hC0 + i);
      step();
    end
    chk("pp_drain_empty", else_valid, 0);
    chk("pp_el_cnt",      else_count, 7);

    // If-count saturation: 7 + 20 accepts clamps at 15.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h0000_0100, 32'hD00 + i); step();
      if (i == 6) chk("sat_cnt_14", if_count, 14);
      if (i == 7) chk("sat_cnt_15", if_count, 15);
    end
    chk("sat_cnt_final", if_count, 15);
    chk("sat_last_head", segment_8_if, 32'hD13);
    drive(1'b0, '0, '0); step();
    chk("sat_if_empty", if_valid, 0);

    // Flush with both branches occupied and an input offered.
    if_ready = 1'b0; else_ready = 1'b0;
    drive(1'b1, 32'd1, 32'hE0); step();
    drive(1'b1, 32'd0, 32'hE1); step();
    chk("fl_pre_if_valid", if_valid, 1);
    chk("fl_pre_el_valid", else_valid, 1);
    flush = 1'b1;
    drive(1'b1, 32'd1, 32'hE2);
    #1;
    chk("fl_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_if_valid", if_valid, 0);
    chk("fl_el_valid", else_valid, 0);
    chk("fl_if_cnt",   if_count, 0);
    chk("fl_el_cnt",   else_count, 0);
    step();
    chk("fl_no_accept", if_valid, 0);

    // Asynchronous reset mid-burst.
    drive(1'b1, 32'd1, 32'hF0); step();
    drive(1'b1, 32'd1, 32'hF1); step();
    chk("ar_pre_if_valid", if_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_if_valid", if_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_seg_if",   segment_8_if, 0);
    chk("ar_if_cnt",   if_count, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, '0, '0);
    if_ready = 1'b1; else_ready = 1'b1;
    step();
    chk("ar_post_if_valid", if_valid, 0);
    chk("ar_post_el_valid", else_valid, 0);
    chk("ar_post_seg_if",   segment_8_if, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/segment_split_unroll.md
# segment_split_unroll

Receive-side counterpart of the unrolled if/else segment combiner. It accepts a stream of combined segment words, each tagged with the condition word that selected it, and steers each word back into a per-branch stream. Each stream is the if-section or the else-section and has its own buffering and valid/ready handshake. It sits downstream of the combine stage, feeding branch-specific post-processing, and keeps per-branch word counts for debug.

## Interface
Parameters:
- DATA_W, 32, width of segment words and condition word.
- DEPTH, 4, entries per branch FIFO; power of two, minimum 2.
- CNT_W, 16, width of per-branch accepted-word counters.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of both FIFOs and counters.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word this cycle.
- input_bit  in  DATA_W  condition word for the current input.
- segment_8_combine  in  DATA_W  combined segment word.
- if_valid  out  1  if-branch head word valid.
- if_ready  in  1  if-branch consumer ready.
- segment_8_if  out  DATA_W  if-branch head word.
- else_valid  out  1  else-branch head word valid.
- else_ready  in  1  else-branch consumer ready.
- segment_8_else  out  DATA_W  else-branch head word.
- if_count  out  CNT_W  words accepted into the if-branch, saturating.
- else_count  out  CNT_W  words accepted into the else-branch, saturating.

## Operation
- The condition is `if_condition = (input_bit != 0)`. The block evaluates it on the accepting cycle only.
- Accept occurs when `in_valid && in_ready` at a rising edge.
  - Condition 1: write `segment_8_combine` to the if FIFO.
  - Condition 0: write `segment_8_combine` to the else FIFO.
- `in_ready = !if_full && !else_full && !flush`.
  - It must not depend on `in_valid` or `input_bit`.
  - It is deliberately conservative: a full FIFO stalls both branches.
- Each FIFO is first-word-fall-through.
  - `X_valid = !X_empty`.
  - `segment_8_X` = head entry.
  - Pop on `X_valid && X_ready`.
- The two branches are fully independent on the output side. Both may pop in the same cycle.
- Pointers are `log2(DEPTH)+1` bits (wrap bit) and wrap modulo 2·DEPTH.
  - Full = equal index bits with opposite wrap bit.
  - Empty = equal pointers.
- Counters:
  - A branch counter increments by 1 on each accept into that branch.
  - It saturates at 2^CNT_W−1 and never wraps.
- Flush has priority over push and pop in the same cycle. It zeroes both FIFOs' pointers and both counters, and no word is accepted that cycle.
- Word order is preserved within each branch. No ordering is defined across branches.
- Data is never modified; width in equals width out.

## Timing
- Reset (reset=0, asynchronous assert; deassert synchronised externally), output values:
  - in_ready=1.
  - if_valid=0, else_valid=0.
  - Both counters 0.
  - Both segment outputs 0.
  - FIFO contents are don't-care, but outputs must read 0 while empty after reset.
- Latency: a word accepted at edge N is presented with X_valid=1 immediately after edge N, so the consumer sees it in cycle N+1.
- Push to an empty FIFO with the consumer ready: the word is popped at edge N+1. There is no combinational in→out path.
- A push and a pop on the same FIFO in the same cycle leave the occupancy unchanged. This is legal at any occupancy below full.
- Full, boundary: in_ready drops in the cycle after the DEPTH-th word is accepted into either FIFO. It rises in the cycle after a pop leaves both FIFOs non-full.
- Empty, boundary: X_valid drops in the cycle after the last word is popped. The head output holds its last value.
- Reset mid-operation: all buffered words are discarded and outputs return to reset values asynchronously.
- Counter update and FIFO write commit on the same edge.

## Test plan
- Reset, then send 4 words with input_bit alternating 1, 0, 1, 0 and data 0xA0..0xA3, both readies held high:
  - if-branch emits 0xA0 then 0xA2; else-branch emits 0xA1 then 0xA3.
  - Each word appears 1 cycle after its accept.
  - if_count=2, else_count=2.
- Hold if_ready=0 and send 4 words with input_bit=0x80000000:
  - in_ready=0 after the 4th accept.
  - The 5th word stalls.
  - Raising if_ready for one cycle restores in_ready on the next cycle.
- Fill the else FIFO to 3 entries, then push and pop else in the same cycle: occupancy stays 3, else_valid stays 1, order is intact.
- Preload with CNT_W=4 and accept 20 if-words: if_count saturates at 15.
- Assert flush with both FIFOs non-empty and in_valid=1:
  - Next cycle if_valid=0, else_valid=0, counts=0.
  - The flush-cycle input is not accepted.
- Assert reset low mid-burst, asynchronously between edges: outputs go to their reset values immediately, and no stale word appears after release.
